// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel 2-flop synchroniser, debouncer, press/release pulses and last-key encoder.
// Optional macro AUTOREPEAT_EN adds auto-repeat press pulses while a button stays held.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             CLK50MHZ,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [2:0]       btn_code,
  output logic             btn_valid
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (N_BTN < 1 || N_BTN > 8 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_param
    $error("btn_conditioner: parameter out of range");
  end

  logic [N_BTN-1:0] sync1, sync2;
  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] repeat_hit;
  logic [N_BTN-1:0] press_next;
  logic [N_BTN-1:0] release_next;
  logic [2:0]       code_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // NOTE: default every always_comb output first so no path leaves a latch behind.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (sync2[i] != btn_level[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == btn_level[i] || accept[i]) cnt[i] <= '0;
        else                                      cnt[i] <= cnt[i] + 1'b1;
      end
      btn_level <= btn_level ^ accept;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] R_FIRST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_NEXT   = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY);

  logic [RW-1:0] rpt_cnt [N_BTN];

  always_comb begin
    repeat_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      repeat_hit[i] = btn_level[i] && !accept[i] &&
                      (rpt_cnt[i] == R_FIRST || rpt_cnt[i] == R_NEXT);
    end
  end

  // After the first repeat the counter cycles between R_RELOAD and R_NEXT, one period apart.
  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (accept[i] || !btn_level[i]) rpt_cnt[i] <= '0;
        else if (rpt_cnt[i] == R_NEXT)  rpt_cnt[i] <= R_RELOAD;
        else                            rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign repeat_hit = '0;
`endif

  assign press_next   = (accept & sync2) | repeat_hit;
  assign release_next = accept & ~sync2;

  always_comb begin
    code_next = 3'd0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_next[i]) code_next = 3'(i);
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_code    <= '0;
      btn_valid   <= 1'b0;
    end else begin
      btn_press   <= press_next;
      btn_release <= release_next;
      btn_valid   <= |press_next;
      if (|press_next) btn_code <= code_next;
    end
  end

endmodule
